// File: rtl/cra_pipe_flags.sv
// Pipelined carry-ripple add/subtract: WIDTH/SEG ripple stages, result and flags leave together.
// Optional sticky overflow bit (sticky_ovf, cleared by ovf_clr) is built when CRA_STICKY_OVF_EN is defined.
module cra_pipe_flags #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             s_flag,
    output logic             zr_flag,
    output logic             c_flag,
    output logic             p_flag,
    output logic             o_flag,
    input  logic             ovf_clr,
    output logic             sticky_ovf
);

    localparam int NSEG = WIDTH / SEG;
    localparam int MSB  = WIDTH - 1;

    // Per-stage state: operands travel whole, z accumulates one finished slice per stage.
    logic [WIDTH-1:0] x_q [NSEG];
    logic [WIDTH-1:0] x_d [NSEG];
    logic [WIDTH-1:0] b_q [NSEG];
    logic [WIDTH-1:0] b_d [NSEG];
    logic [WIDTH-1:0] z_q [NSEG];
    logic [WIDTH-1:0] z_d [NSEG];
    logic [NSEG-1:0]  v_q, v_d;
    logic [NSEG-1:0]  c_q, c_d;
    logic [NSEG-1:0]  zr_q, zr_d;
    logic [NSEG-1:0]  p_q, p_d;
    logic             o_q, o_d;
    logic             adv;

    always_comb begin
        adv = ~v_q[NSEG-1] | out_ready;
    end

    assign in_ready = adv;

    always_comb begin
        // NOTE: these are scratch values rebuilt on every pass, so blocking '=' is
        // correct here; only the always_ff below uses '<=' to update real state.
        logic [WIDTH-1:0] sx, sb, sz;
        logic             sc, sv, szr, sp;
        logic [SEG:0]     sum;

        sx  = x;
        sb  = sub ? ~y : y;
        sz  = '0;
        sc  = sub | cin;
        sv  = in_valid;
        szr = 1'b1;
        sp  = 1'b0;
        o_d = o_q;

        for (int k = 0; k < NSEG; k++) begin
            sum = {1'b0, sx[k*SEG +: SEG]} + {1'b0, sb[k*SEG +: SEG]} + {{SEG{1'b0}}, sc};
            sz[k*SEG +: SEG] = sum[SEG-1:0];

            x_d[k]  = adv ? sx : x_q[k];
            b_d[k]  = adv ? sb : b_q[k];
            z_d[k]  = adv ? sz : z_q[k];
            v_d[k]  = adv ? sv : v_q[k];
            c_d[k]  = adv ? sum[SEG] : c_q[k];
            zr_d[k] = adv ? (szr & ~|sum[SEG-1:0]) : zr_q[k];
            // Partial parity is odd parity; the last stage flips it to the even-parity flag.
            p_d[k]  = adv ? (sp ^ (^sum[SEG-1:0]) ^ (k == NSEG - 1)) : p_q[k];

            if (k == NSEG - 1) begin
                o_d = adv ? ((sx[MSB] & sb[MSB] & ~sum[SEG-1]) |
                             (~sx[MSB] & ~sb[MSB] & sum[SEG-1])) : o_q;
            end else begin
                sx  = x_q[k];
                sb  = b_q[k];
                sz  = z_q[k];
                sc  = c_q[k];
                sv  = v_q[k];
                szr = zr_q[k];
                sp  = p_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, not just valids, because z and
            // every flag must read 0 straight out of reset.
            v_q  <= '0;
            c_q  <= '0;
            zr_q <= '0;
            p_q  <= '0;
            o_q  <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                x_q[k] <= '0;
                b_q[k] <= '0;
                z_q[k] <= '0;
            end
        end else begin
            v_q  <= v_d;
            c_q  <= c_d;
            zr_q <= zr_d;
            p_q  <= p_d;
            o_q  <= o_d;
            for (int k = 0; k < NSEG; k++) begin
                x_q[k] <= x_d[k];
                b_q[k] <= b_d[k];
                z_q[k] <= z_d[k];
            end
        end
    end

    assign out_valid = v_q[NSEG-1];
    assign z         = z_q[NSEG-1];
    assign s_flag    = z_q[NSEG-1][MSB];
    assign zr_flag   = zr_q[NSEG-1];
    assign c_flag    = c_q[NSEG-1];
    assign p_flag    = p_q[NSEG-1];
    assign o_flag    = o_q;

`ifdef CRA_STICKY_OVF_EN
    logic sticky_q, sticky_d;

    // A set on this cycle's output handshake overrides a simultaneous clear.
    always_comb begin
        sticky_d = sticky_q;
        if (ovf_clr) begin
            sticky_d = 1'b0;
        end
        if (out_valid & out_ready & o_q) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_ovf = sticky_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign sticky_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_cra_pipe_flags.sv
// Randomized self-checking bench for cra_pipe_flags against a full-width arithmetic reference.
// Honours CRA_STICKY_OVF_EN the same way the design does.
module tb_cra_pipe_flags;

    localparam int WIDTH = 64;
    localparam int SEG   = 16;
    localparam int NSEG  = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             sub = 1'b0;
    logic             cin = 1'b0;
    logic             out_ready = 1'b0;
    logic             ovf_clr = 1'b0;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] z;
    logic             s_flag, zr_flag, c_flag, p_flag, o_flag, sticky_ovf;

    cra_pipe_flags #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .sub        (sub),
        .cin        (cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .z          (z),
        .s_flag     (s_flag),
        .zr_flag    (zr_flag),
        .c_flag     (c_flag),
        .p_flag     (p_flag),
        .o_flag     (o_flag),
        .ovf_clr    (ovf_clr),
        .sticky_ovf (sticky_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] z;
        logic             s;
        logic             zr;
        logic             c;
        logic             p;
        logic             o;
    } res_t;

    // Reference: a delay line of expected results that only moves when the unit may advance.
    res_t pipe_m [NSEG];
    bit   vld_m  [NSEG];
    bit   sticky_m;
    int   checks;
    int   errors;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic res_t golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] bb,
                                    input logic s, input logic ci);
        res_t                    r;
        logic [WIDTH+1:0]        uw;
        logic signed [WIDTH+1:0] sw, lim_hi, lim_lo;
        lim_hi = {3'b000, {(WIDTH-1){1'b1}}};
        lim_lo = {3'b111, {(WIDTH-1){1'b0}}};
        if (s) begin
            uw  = {2'b00, a} - {2'b00, bb};
            sw  = {{2{a[WIDTH-1]}}, a} - {{2{bb[WIDTH-1]}}, bb};
            r.c = (a >= bb);
        end else begin
            uw  = {2'b00, a} + {2'b00, bb} + {{(WIDTH+1){1'b0}}, ci};
            sw  = {{2{a[WIDTH-1]}}, a} + {{2{bb[WIDTH-1]}}, bb} + {{(WIDTH+1){1'b0}}, ci};
            r.c = uw[WIDTH];
        end
        r.z  = uw[WIDTH-1:0];
        r.s  = r.z[WIDTH-1];
        r.zr = (r.z == '0);
        r.p  = ~^r.z;
        r.o  = (sw > lim_hi) || (sw < lim_lo);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NSEG; k++) vld_m[k] = 1'b0;
        sticky_m = 1'b0;
    endtask

    // Called just after a rising edge; the driven inputs are still the ones that edge sampled.
    task automatic model_step();
        bit adv;
        adv = !vld_m[NSEG-1] || out_ready;
        if (vld_m[NSEG-1] && out_ready && pipe_m[NSEG-1].o) sticky_m = 1'b1;
        else if (ovf_clr) sticky_m = 1'b0;
        if (adv) begin
            for (int k = NSEG - 1; k > 0; k--) begin
                vld_m[k]  = vld_m[k-1];
                pipe_m[k] = pipe_m[k-1];
            end
            vld_m[0]  = in_valid;
            pipe_m[0] = golden(x, y, sub, cin);
        end
    endtask

    task automatic compare();
        logic exp_sticky;
`ifdef CRA_STICKY_OVF_EN
        exp_sticky = sticky_m;
`else
        exp_sticky = 1'b0;
`endif
        check("in_ready", WIDTH'(in_ready), WIDTH'(!vld_m[NSEG-1] || out_ready));
        check("out_valid", WIDTH'(out_valid), WIDTH'(vld_m[NSEG-1]));
        check("sticky_ovf", WIDTH'(sticky_ovf), WIDTH'(exp_sticky));
        if (vld_m[NSEG-1]) begin
            check("z", z, pipe_m[NSEG-1].z);
            check("s_flag", WIDTH'(s_flag), WIDTH'(pipe_m[NSEG-1].s));
            check("zr_flag", WIDTH'(zr_flag), WIDTH'(pipe_m[NSEG-1].zr));
            check("c_flag", WIDTH'(c_flag), WIDTH'(pipe_m[NSEG-1].c));
            check("p_flag", WIDTH'(p_flag), WIDTH'(pipe_m[NSEG-1].p));
            check("o_flag", WIDTH'(o_flag), WIDTH'(pipe_m[NSEG-1].o));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_out_valid", WIDTH'(out_valid), '0);
        check("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
        check("rst_z", z, '0);
        check("rst_flags", WIDTH'({s_flag, zr_flag, c_flag, p_flag, o_flag}), '0);
        check("rst_sticky", WIDTH'(sticky_ovf), '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (NSEG + 1) tick();
    endtask

    task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] bb,
                            input logic s, input logic ci, input logic [WIDTH-1:0] exp_z,
                            input logic exp_s, input logic exp_zr, input logic exp_c,
                            input logic exp_p, input logic exp_o);
        int lat;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        x   = a;
        y   = bb;
        sub = s;
        cin = ci;
        lat = 0;
        do begin
            tick();
            lat++;
            in_valid = 1'b0;
        end while (!out_valid && lat < 20);
        check({tag, "_latency"}, WIDTH'(lat), WIDTH'(NSEG));
        check({tag, "_z"}, z, exp_z);
        check({tag, "_s"}, WIDTH'(s_flag), WIDTH'(exp_s));
        check({tag, "_zr"}, WIDTH'(zr_flag), WIDTH'(exp_zr));
        check({tag, "_c"}, WIDTH'(c_flag), WIDTH'(exp_c));
        check({tag, "_p"}, WIDTH'(p_flag), WIDTH'(exp_p));
        check({tag, "_o"}, WIDTH'(o_flag), WIDTH'(exp_o));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_v;
        checks = 0;
        errors = 0;
        model_clear();
        repeat (2) @(negedge clk);
        do_reset();
        drain();

        directed("add_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0,
                 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        directed("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("sub_noborrow", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        directed("add_cin", 64'd1, 64'd2, 1'b0, 1'b1, 64'd4,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Eight beats back to back: results 0,2,..,14 on consecutive cycles.
        out_ready = 1'b1;
        sub = 1'b0;
        cin = 1'b0;
        for (int j = 1; j <= NSEG + 9; j++) begin
            if (j <= 8) begin
                in_valid = 1'b1;
                x = WIDTH'(j - 1);
                y = WIDTH'(j - 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            exp_v = (j >= NSEG) && (j < NSEG + 8);
            check("stream_valid", WIDTH'(out_valid), WIDTH'(exp_v));
            if (exp_v) check("stream_z", z, WIDTH'(2 * (j - NSEG)));
        end
        drain();

        // Three beats in flight, then five cycles of output stall while beats keep being offered.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x   = pick();
            y   = pick();
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x = pick();
            y = pick();
            tick();
        end
        out_ready = 1'b1;
        drain();

        // Reset with three beats in flight: nothing may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x = pick();
            y = pick();
            tick();
        end
        in_valid = 1'b0;
        do_reset();
        for (int i = 0; i < NSEG + 3; i++) begin
            tick();
            check("rst_no_output", WIDTH'(out_valid), '0);
        end

        directed("ovf_again", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        drain();

        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            x   = pick();
            y   = pick();
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            tick();
        end
        ovf_clr = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
